postproc_seq_ctrl: RTL and testbench
====================================

// Module: postproc_seq_ctrl
// PURPOSE
//  Sequences the post-CONV datapath (ReLU -> residual add -> quantization) for one layer tile.
//  - Latches per-layer config on start and holds it static on cfg_* while busy.
//  - Pops accumulator FIFO; reads identity SRAM in lock-step (residual layers only).
//  - Tracks the 1-cycle registered post_out; writes quantized pixels to output SRAM.
//  - Sits between conv accumulator FIFO, identity SRAM, postproc datapath and output SRAM.
// PARAMETERS
//  ADDR_W   10        identity/output SRAM address width
//  PIX_W    12        pixel-group counter width (max tile = 2^PIX_W-1 groups)
//  FL_W     `BW_FL    fractional-length field width
// PORTS
//  clk          in   1         clock
//  rst_n        in   1         asynchronous active-low reset
//  start        in   1         1-cycle pulse; accepted only in IDLE
//  num_pix      in   PIX_W     pixel groups (OUT_CHANNEL ch each) in this tile
//  relu_i       in   1         layer ReLU enable
//  residual_i   in   1         layer residual enable
//  ftr_fl_i     in   4*FL_W    input-feature fl, one per channel
//  wgt_fl_i     in   FL_W      weight fl
//  idt_fl_i     in   4*FL_W    identity fl
//  out_fl_i     in   4*FL_W    output fl
//  idt_base     in   ADDR_W    identity SRAM start address
//  out_base     in   ADDR_W    output SRAM start address
//  acc_empty    in   1         accumulator FIFO empty
//  acc_pop      out  1         FIFO pop; data valid at postproc input next cycle
//  idt_rd_en    out  1         identity SRAM read enable (1-cycle read latency)
//  idt_addr     out  ADDR_W    identity read address
//  cfg_relu/cfg_residual  out 1     latched config to postproc
//  cfg_ftr_fl/cfg_idt_fl/cfg_out_fl out 4*FL_W; cfg_wgt_fl out FL_W   latched fl to postproc
//  out_wr_en    out  1         output SRAM write enable, aligned with post_out
//  out_addr     out  ADDR_W    output write address
//  busy         out  1         high from start accept until done
//  done         out  1         1-cycle pulse after last write
// BEHAVIOUR
//  - Reset: every output 0; cfg_* 0; counters 0; state IDLE; pipeline valids cleared.
//  - FSM IDLE -> RUN on start (latch all *_i, bases, num_pix; busy=1 next cycle).
//    - num_pix==0: IDLE -> DONE directly, no pops/writes.
//  - RUN, cycle t, issue when !acc_empty && issued<num_pix:
//    - acc_pop=1; idt_rd_en=residual; idt_addr=idt_base+issued.
//  - t+1: data at postproc input (v1). t+2: post_out valid; out_wr_en=1, out_addr=out_base+k.
//  - Fixed issue-to-write latency 2; at most one issue per cycle; order preserved.
//  - RUN -> DRAIN in the cycle the last issue occurs; DRAIN -> DONE when v1 and v2 clear.
//  - DONE: done=1 one cycle; busy=0 same cycle; -> IDLE.
//  - acc_empty gaps stall issue only; in-flight entries still retire on schedule.
//  - Addresses are ADDR_W-bit modular: base+count wraps past 2^ADDR_W-1 to 0.
//  - start while busy: ignored; latched config unchanged.
//  - start and done in the same cycle: start ignored (FSM in DONE, not IDLE).
//  - residual=0: idt_rd_en held 0 for the whole tile.
//  - cfg_* change only on accepted start; stable while busy.
//  - rst_n low mid-tile: immediate return to reset values; in-flight writes dropped.
// STRUCTURE
//  - postproc_ctrl_defs.vh (shared include): state encodings IDLE/RUN/DRAIN/DONE;
//    POST_LAT=2 issue-to-write latency constant.
//  - Single module, no sub-module; 2-entry valid/addr shift pipeline inlined.
// TESTING
//  - num_pix=4, FIFO never empty, residual=1, idt_base=0x010, out_base=0x200:
//    -> pops t..t+3; idt_addr 0x010..0x013; writes 0x200..0x203 at t+2..t+5; done at t+6.
//  - residual=0, num_pix=3 -> idt_rd_en never 1; exactly 3 out_wr_en; done once.
//  - acc_empty high 2 cycles after 1st pop, num_pix=3 -> write gap 2 cycles;
//    addresses contiguous; total 3 writes.
//  - out_base=0x3FE (ADDR_W=10), num_pix=4 -> out_addr 0x3FE,0x3FF,0x000,0x001.
//  - num_pix=0 -> zero pops/writes; done pulses; busy returns 0.
//  - Second start mid-tile ignored, cfg_* unchanged; rst_n low at 2nd write ->
//    all outputs 0 next edge, FSM IDLE, no further writes.

Source files
------------

// File: rtl/postproc_seq_ctrl_pkg.sv
// Shared definitions for the post-CONV sequencer: FSM states, pipeline latency
// and default field widths.
package postproc_seq_ctrl_pkg;

    localparam int unsigned BW_FL    = 5;
    localparam int unsigned POST_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/postproc_seq_ctrl.sv
// Sequences ReLU -> residual add -> quantization for one layer tile: pops the
// accumulator FIFO, reads identity SRAM in lock-step, writes output SRAM.
module postproc_seq_ctrl
    import postproc_seq_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned PIX_W  = 12,
    parameter int unsigned FL_W   = BW_FL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PIX_W-1:0]    num_pix,
    input  logic                relu_i,
    input  logic                residual_i,
    input  logic [4*FL_W-1:0]   ftr_fl_i,
    input  logic [FL_W-1:0]     wgt_fl_i,
    input  logic [4*FL_W-1:0]   idt_fl_i,
    input  logic [4*FL_W-1:0]   out_fl_i,
    input  logic [ADDR_W-1:0]   idt_base,
    input  logic [ADDR_W-1:0]   out_base,
    input  logic                acc_empty,
    output logic                acc_pop,
    output logic                idt_rd_en,
    output logic [ADDR_W-1:0]   idt_addr,
    output logic                cfg_relu,
    output logic                cfg_residual,
    output logic [4*FL_W-1:0]   cfg_ftr_fl,
    output logic [FL_W-1:0]     cfg_wgt_fl,
    output logic [4*FL_W-1:0]   cfg_idt_fl,
    output logic [4*FL_W-1:0]   cfg_out_fl,
    output logic                out_wr_en,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                busy,
    output logic                done
);

    state_e                           state_q, state_d;
    logic [PIX_W-1:0]                 num_pix_q;
    logic [PIX_W-1:0]                 issued_q, issued_d;
    logic [ADDR_W-1:0]                idt_base_q, out_base_q;
    logic                             relu_q, residual_q;
    logic [4*FL_W-1:0]                ftr_fl_q, idt_fl_q, out_fl_q;
    logic [FL_W-1:0]                  wgt_fl_q;
    logic [POST_LAT-1:0]              vld_q;
    logic [POST_LAT-1:0][ADDR_W-1:0]  wa_q;
    logic                             accept, issue, in_flight;

    assign accept = (state_q == ST_IDLE) && start;
    assign issue  = (state_q == ST_RUN) && !acc_empty && (issued_q < num_pix_q);
    // The last stage retires this cycle regardless, so only earlier stages hold DRAIN.
    assign in_flight = |vld_q[POST_LAT-2:0];

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    issued_d = '0;
                    state_d  = (num_pix == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    issued_d = issued_q + PIX_W'(1);
                    if (issued_q + PIX_W'(1) == num_pix_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (!in_flight) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            issued_q   <= '0;
            num_pix_q  <= '0;
            idt_base_q <= '0;
            out_base_q <= '0;
            relu_q     <= 1'b0;
            residual_q <= 1'b0;
            ftr_fl_q   <= '0;
            wgt_fl_q   <= '0;
            idt_fl_q   <= '0;
            out_fl_q   <= '0;
            vld_q      <= '0;
            wa_q       <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            if (accept) begin
                num_pix_q  <= num_pix;
                idt_base_q <= idt_base;
                out_base_q <= out_base;
                relu_q     <= relu_i;
                residual_q <= residual_i;
                ftr_fl_q   <= ftr_fl_i;
                wgt_fl_q   <= wgt_fl_i;
                idt_fl_q   <= idt_fl_i;
                out_fl_q   <= out_fl_i;
            end
            vld_q <= {vld_q[POST_LAT-2:0], issue};
            wa_q  <= {wa_q[POST_LAT-2:0], out_base_q + ADDR_W'(issued_q)};
        end
    end

    assign acc_pop      = issue;
    assign idt_rd_en    = issue && residual_q;
    assign idt_addr     = issue ? (idt_base_q + ADDR_W'(issued_q)) : '0;
    assign out_wr_en    = vld_q[POST_LAT-1];
    assign out_addr     = wa_q[POST_LAT-1];
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign cfg_relu     = relu_q;
    assign cfg_residual = residual_q;
    assign cfg_ftr_fl   = ftr_fl_q;
    assign cfg_wgt_fl   = wgt_fl_q;
    assign cfg_idt_fl   = idt_fl_q;
    assign cfg_out_fl   = out_fl_q;

endmodule

// File: tb/tb_postproc_seq_ctrl.sv
// Directed bench for postproc_seq_ctrl: logs pops/reads/writes/done per cycle
// and compares against hand-computed schedules.
module tb_postproc_seq_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned PIX_W  = 12;
    localparam int unsigned FL_W   = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [PIX_W-1:0]    num_pix = '0;
    logic                relu_i = 1'b0;
    logic                residual_i = 1'b0;
    logic [4*FL_W-1:0]   ftr_fl_i = '0;
    logic [FL_W-1:0]     wgt_fl_i = '0;
    logic [4*FL_W-1:0]   idt_fl_i = '0;
    logic [4*FL_W-1:0]   out_fl_i = '0;
    logic [ADDR_W-1:0]   idt_base = '0;
    logic [ADDR_W-1:0]   out_base = '0;
    logic                acc_empty = 1'b0;
    logic                acc_pop, idt_rd_en, out_wr_en, busy, done;
    logic [ADDR_W-1:0]   idt_addr, out_addr;
    logic                cfg_relu, cfg_residual;
    logic [4*FL_W-1:0]   cfg_ftr_fl, cfg_idt_fl, cfg_out_fl;
    logic [FL_W-1:0]     cfg_wgt_fl;

    postproc_seq_ctrl #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .FL_W(FL_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_pix(num_pix),
        .relu_i(relu_i), .residual_i(residual_i), .ftr_fl_i(ftr_fl_i),
        .wgt_fl_i(wgt_fl_i), .idt_fl_i(idt_fl_i), .out_fl_i(out_fl_i),
        .idt_base(idt_base), .out_base(out_base), .acc_empty(acc_empty),
        .acc_pop(acc_pop), .idt_rd_en(idt_rd_en), .idt_addr(idt_addr),
        .cfg_relu(cfg_relu), .cfg_residual(cfg_residual), .cfg_ftr_fl(cfg_ftr_fl),
        .cfg_wgt_fl(cfg_wgt_fl), .cfg_idt_fl(cfg_idt_fl), .cfg_out_fl(cfg_out_fl),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pop_cyc[$];
    int wr_cyc[$];
    int done_cyc[$];
    logic [ADDR_W-1:0] idt_log[$];
    logic [ADDR_W-1:0] wr_addr[$];
    int busy_at_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_pop) pop_cyc.push_back(cyc);
            if (idt_rd_en) idt_log.push_back(idt_addr);
            if (out_wr_en) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(out_addr);
            end
            if (done) begin
                done_cyc.push_back(cyc);
                if (busy) busy_at_done++;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        pop_cyc.delete();
        wr_cyc.delete();
        done_cyc.delete();
        idt_log.delete();
        wr_addr.delete();
        busy_at_done = 0;
    endtask

    task automatic run_tile(input int np, input logic rl, input logic rs,
                            input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] ob,
                            input bit gap);
        bit got_done;
        got_done = 0;
        clear_logs();
        @(posedge clk); #1;
        num_pix = PIX_W'(np); relu_i = rl; residual_i = rs;
        idt_base = ib; out_base = ob; acc_empty = 1'b0;
        ftr_fl_i = 20'h12345; wgt_fl_i = 5'h0B; idt_fl_i = 20'h6789A; out_fl_i = 20'hBCDEF;
        start = 1'b1;
        for (int n = 0; n < 60 && !got_done; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (gap && pop_cyc.size() > 0)
                acc_empty = (cyc > pop_cyc[0]) && (cyc <= pop_cyc[0] + 2);
            if (done_cyc.size() > 0) got_done = 1;
        end
        if (!got_done) check_val("done_timeout", 0, 1);
        acc_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_logs(input string tag, input int n_pop, input int n_idt,
                              input logic [ADDR_W-1:0] idt0, input logic [ADDR_W-1:0] wr0,
                              input int pop_rel[8], input int wr_rel[8], input int done_rel);
        logic [ADDR_W-1:0] e;
        check_val({tag, "_pops"}, pop_cyc.size(), n_pop);
        check_val({tag, "_idt_rds"}, idt_log.size(), n_idt);
        check_val({tag, "_writes"}, wr_cyc.size(), n_pop);
        check_val({tag, "_dones"}, done_cyc.size(), 1);
        check_val({tag, "_busy_at_done"}, busy_at_done, 0);
        if (idt_log.size() == n_idt)
            for (int i = 0; i < n_idt; i++) begin
                e = idt0 + ADDR_W'(i);
                check_val($sformatf("%s_idt_addr%0d", tag, i), idt_log[i], e);
            end
        if (pop_cyc.size() == n_pop && wr_cyc.size() == n_pop)
            for (int i = 0; i < n_pop; i++) begin
                e = wr0 + ADDR_W'(i);
                check_val($sformatf("%s_pop_t%0d", tag, i), pop_cyc[i] - pop_cyc[0], pop_rel[i]);
                check_val($sformatf("%s_wr_t%0d", tag, i), wr_cyc[i] - pop_cyc[0], wr_rel[i]);
                check_val($sformatf("%s_wr_addr%0d", tag, i), wr_addr[i], e);
            end
        if (n_pop > 0 && pop_cyc.size() > 0 && done_cyc.size() > 0)
            check_val({tag, "_done_t"}, done_cyc[0] - pop_cyc[0], done_rel);
    endtask

    task automatic check_outs_zero(input string tag);
        check_val({tag, "_outs"}, {acc_pop, idt_rd_en, idt_addr, out_wr_en, out_addr,
                                   busy, done, cfg_relu, cfg_residual, cfg_wgt_fl}, 0);
        check_val({tag, "_cfg_fl"}, {cfg_ftr_fl, cfg_idt_fl, cfg_out_fl}, 0);
    endtask

    initial begin
        #12;
        check_outs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outs_zero("idle");

        // basic residual tile
        run_tile(4, 1'b1, 1'b1, 10'h010, 10'h200, 0);
        check_logs("t1", 4, 4, 10'h010, 10'h200,
                   '{0, 1, 2, 3, 0, 0, 0, 0}, '{2, 3, 4, 5, 0, 0, 0, 0}, 6);
        check_val("t1_cfg", {cfg_relu, cfg_residual, cfg_wgt_fl}, {1'b1, 1'b1, 5'h0B});
        check_val("t1_cfg_fl", {cfg_ftr_fl, cfg_idt_fl, cfg_out_fl}, {20'h12345, 20'h6789A, 20'hBCDEF});
        check_val("t1_busy_after", busy, 0);

        // no residual: identity SRAM untouched
        run_tile(3, 1'b0, 1'b0, 10'h040, 10'h080, 0);
        check_logs("t2", 3, 0, 10'h040, 10'h080,
                   '{0, 1, 2, 0, 0, 0, 0, 0}, '{2, 3, 4, 0, 0, 0, 0, 0}, 5);
        check_val("t2_cfg_residual", cfg_residual, 0);

        // FIFO empty for 2 cycles after the first pop
        run_tile(3, 1'b0, 1'b1, 10'h020, 10'h100, 1);
        check_logs("t3", 3, 3, 10'h020, 10'h100,
                   '{0, 3, 4, 0, 0, 0, 0, 0}, '{2, 5, 6, 0, 0, 0, 0, 0}, 7);

        // address wrap on both SRAMs
        run_tile(4, 1'b1, 1'b1, 10'h3FF, 10'h3FE, 0);
        check_logs("t4", 4, 4, 10'h3FF, 10'h3FE,
                   '{0, 1, 2, 3, 0, 0, 0, 0}, '{2, 3, 4, 5, 0, 0, 0, 0}, 6);

        // empty tile
        run_tile(0, 1'b1, 1'b1, 10'h010, 10'h200, 0);
        check_val("t5_pops", pop_cyc.size(), 0);
        check_val("t5_writes", wr_cyc.size(), 0);
        check_val("t5_dones", done_cyc.size(), 1);
        check_val("t5_busy", busy, 0);

        // ignored restart, then reset in the middle of the tile
        clear_logs();
        @(posedge clk); #1;
        num_pix = 12'd6; relu_i = 1'b1; residual_i = 1'b1;
        idt_base = 10'h100; out_base = 10'h300;
        ftr_fl_i = 20'hABCDE; wgt_fl_i = 5'h15; idt_fl_i = 20'h13579; out_fl_i = 20'h0F0F0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 20 && pop_cyc.size() == 0; n++) begin
            @(posedge clk); #1;
        end
        check_val("t6_first_pop", pop_cyc.size(), 1);
        relu_i = 1'b0; residual_i = 1'b0;
        ftr_fl_i = 20'h11111; wgt_fl_i = 5'h02; idt_fl_i = 20'h22222; out_fl_i = 20'h33333;
        num_pix = 12'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("t6_cfg", {cfg_relu, cfg_residual, cfg_wgt_fl}, {1'b1, 1'b1, 5'h15});
        check_val("t6_cfg_fl", {cfg_ftr_fl, cfg_idt_fl, cfg_out_fl}, {20'hABCDE, 20'h13579, 20'h0F0F0});
        check_val("t6_busy", busy, 1);
        for (int n = 0; n < 20 && wr_cyc.size() < 2; n++) begin
            @(negedge clk); #1;
        end
        check_val("t6_two_writes", wr_cyc.size(), 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_outs_zero("t6_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_val("t6_writes_after_rst", wr_cyc.size(), 2);
        check_val("t6_no_done", done_cyc.size(), 0);
        check_val("t6_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
